// File: rtl/issue_unit_pkg.sv
// Shared types and sizes for the dual-issue steering stage.
package issue_unit_pkg;

  localparam int NUM_REGISTERS_LOG2 = 5;
  localparam int ISSUE_DEPTH        = 4;
  localparam int ISSUE_ENTRY_BITS   = 32 + 32 + 3 * NUM_REGISTERS_LOG2 + 3;

  typedef logic [NUM_REGISTERS_LOG2-1:0] reg_idx_t;

  // One decoded instruction as it sits in the buffer; field order fixes the packed layout.
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    reg_idx_t    rs;
    reg_idx_t    rt;
    reg_idx_t    dst;
    logic        reg_write;
    logic        mem_read;
    logic        mem_write;
  } entry_t;

  // Slot 0 is the ALU-only pipe, so it carries no memory controls.
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    reg_idx_t    rs;
    reg_idx_t    rt;
    reg_idx_t    dst;
    logic        reg_write;
  } slot0_t;

  function automatic logic is_mem_op(input entry_t e);
    return e.mem_read | e.mem_write;
  endfunction

endpackage

// File: rtl/issue_unit_buffer.sv
// Dual-push / dual-pop circular FIFO exposing the two oldest entries (H0, H1).
// DEPTH must be a power of two and at least 2 so pointers wrap naturally.
module issue_unit_buffer
  import issue_unit_pkg::*;
#(
  parameter int DEPTH = ISSUE_DEPTH
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     i_clear,
  input  logic [1:0]               i_push_cnt,
  input  entry_t                   i_push0,
  input  entry_t                   i_push1,
  input  logic [1:0]               i_pop_cnt,
  output entry_t                   o_h0,
  output entry_t                   o_h1,
  output logic [$clog2(DEPTH):0]   o_count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [ISSUE_ENTRY_BITS-1:0] r_mem [DEPTH];
  logic [PW-1:0]               r_wr_ptr;
  logic [PW-1:0]               r_rd_ptr;
  logic [CW-1:0]               r_count;
  logic [PW-1:0]               w_wr_ptr1;
  logic [PW-1:0]               w_rd_ptr1;

  assign w_wr_ptr1 = r_wr_ptr + PW'(1);
  assign w_rd_ptr1 = r_rd_ptr + PW'(1);

  // Entry storage: older pushed entry lands at the write pointer, younger one right after it.
  always_ff @(posedge clk) begin
    if (i_push_cnt != 2'd0) r_mem[r_wr_ptr] <= i_push0;
    if (i_push_cnt == 2'd2) r_mem[w_wr_ptr1] <= i_push1;
  end

  // Pointer and occupancy bookkeeping; clear empties the buffer without touching storage.
  always_ff @(posedge clk) begin
    if (reset || i_clear) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      r_wr_ptr <= r_wr_ptr + PW'(i_push_cnt);
      r_rd_ptr <= r_rd_ptr + PW'(i_pop_cnt);
      r_count  <= r_count + CW'(i_push_cnt) - CW'(i_pop_cnt);
    end
  end

  assign o_h0    = entry_t'(r_mem[r_rd_ptr]);
  assign o_h1    = entry_t'(r_mem[w_rd_ptr1]);
  assign o_count = r_count;

endmodule

// File: rtl/issue_unit.sv
// Dual-issue steering stage: buffers decoded instructions in order and places up to
// two per cycle into slot 0 (ALU) and slot 1 (ALU + memory), with pairing hazards,
// single-memory-pipe rule and a one-cycle load-use bubble.
module issue_unit
  import issue_unit_pkg::*;
#(
  parameter int DEPTH = ISSUE_DEPTH
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          flush,
  input  logic                          stall,
  input  logic [1:0]                    in_valid,
  output logic                          in_ready,
  input  logic [31:0]                   in0_pc,
  input  logic [31:0]                   in1_pc,
  input  logic [31:0]                   in0_instr,
  input  logic [31:0]                   in1_instr,
  input  logic [NUM_REGISTERS_LOG2-1:0] in0_rs,
  input  logic [NUM_REGISTERS_LOG2-1:0] in0_rt,
  input  logic [NUM_REGISTERS_LOG2-1:0] in0_dst,
  input  logic [NUM_REGISTERS_LOG2-1:0] in1_rs,
  input  logic [NUM_REGISTERS_LOG2-1:0] in1_rt,
  input  logic [NUM_REGISTERS_LOG2-1:0] in1_dst,
  input  logic                          in0_reg_write,
  input  logic                          in0_mem_read,
  input  logic                          in0_mem_write,
  input  logic                          in1_reg_write,
  input  logic                          in1_mem_read,
  input  logic                          in1_mem_write,
  output logic                          slot0_valid,
  output logic [31:0]                   slot0_pc,
  output logic [31:0]                   slot0_instr,
  output logic [NUM_REGISTERS_LOG2-1:0] slot0_rs,
  output logic [NUM_REGISTERS_LOG2-1:0] slot0_rt,
  output logic [NUM_REGISTERS_LOG2-1:0] slot0_dst,
  output logic                          slot0_reg_write,
  output logic                          slot1_valid,
  output logic [31:0]                   slot1_pc,
  output logic [31:0]                   slot1_instr,
  output logic [NUM_REGISTERS_LOG2-1:0] slot1_rs,
  output logic [NUM_REGISTERS_LOG2-1:0] slot1_rt,
  output logic [NUM_REGISTERS_LOG2-1:0] slot1_dst,
  output logic                          slot1_reg_write,
  output logic                          slot1_mem_read,
  output logic                          slot1_mem_write,
  output logic                          first
);

  localparam int CW = $clog2(DEPTH) + 1;

  entry_t        w_in0;
  entry_t        w_in1;
  entry_t        w_h0;
  entry_t        w_h1;
  logic [CW-1:0] w_count;
  logic          w_push_en;
  logic [1:0]    w_push_cnt;
  logic [1:0]    w_pop_cnt;

  logic          w_h0_mem;
  logic          w_h1_mem;
  logic          w_h0_blocked;
  logic          w_h1_blocked;
  logic          w_raw;
  logic          w_issue0;
  logic          w_pair;
  logic          w_s0_valid;
  logic          w_s1_valid;
  logic          w_first;
  slot0_t        w_s0;
  entry_t        w_s1;

  slot0_t        r_s0;
  entry_t        r_s1;
  logic          r_s0_valid;
  logic          r_s1_valid;
  logic          r_first;
  logic          r_ld_valid;
  reg_idx_t      r_ld_dst;

  assign w_in0 = '{pc: in0_pc, instr: in0_instr, rs: in0_rs, rt: in0_rt, dst: in0_dst,
                   reg_write: in0_reg_write, mem_read: in0_mem_read, mem_write: in0_mem_write};
  assign w_in1 = '{pc: in1_pc, instr: in1_instr, rs: in1_rs, rt: in1_rt, dst: in1_dst,
                   reg_write: in1_reg_write, mem_read: in1_mem_read, mem_write: in1_mem_write};

  // Readiness uses the registered count only, so it ignores this cycle's pop.
  assign in_ready   = (w_count <= CW'(DEPTH - 2));
  assign w_push_en  = in_valid[0] && in_ready && !flush;
  assign w_push_cnt = !w_push_en ? 2'd0 : (in_valid[1] ? 2'd2 : 2'd1);
  assign w_pop_cnt  = (flush || stall) ? 2'd0 : (w_pair ? 2'd2 : (w_issue0 ? 2'd1 : 2'd0));

  issue_unit_buffer #(.DEPTH(DEPTH)) u_buffer (
    .clk        (clk),
    .reset      (reset),
    .i_clear    (flush),
    .i_push_cnt (w_push_cnt),
    .i_push0    (w_in0),
    .i_push1    (w_in1),
    .i_pop_cnt  (w_pop_cnt),
    .o_h0       (w_h0),
    .o_h1       (w_h1),
    .o_count    (w_count)
  );

  // Pairing and hazard decision for the two oldest entries.
  always_comb begin
    w_h0_mem     = is_mem_op(w_h0);
    w_h1_mem     = is_mem_op(w_h1);
    w_h0_blocked = r_ld_valid && ((w_h0.rs == r_ld_dst) || (w_h0.rt == r_ld_dst));
    w_h1_blocked = r_ld_valid && ((w_h1.rs == r_ld_dst) || (w_h1.rt == r_ld_dst));
    w_raw        = w_h0.reg_write && (w_h0.dst != '0) &&
                   ((w_h1.rs == w_h0.dst) || (w_h1.rt == w_h0.dst));
    w_issue0     = (w_count != '0) && !w_h0_blocked;
    w_pair       = w_issue0 && (w_count >= CW'(2)) && !w_h1_blocked &&
                   !(w_h0_mem && w_h1_mem) && !w_raw;
  end

  // Slot placement: memory ops always ride slot 1; first=0 only when a mem-op H0 leads a pair.
  always_comb begin
    w_s0_valid = w_issue0 && (w_pair || !w_h0_mem);
    w_s1_valid = w_issue0 && (w_pair || w_h0_mem);
    w_first    = !(w_pair && w_h0_mem);
    w_s1       = (w_pair && !w_h0_mem) ? w_h1 : w_h0;
    if (w_pair && w_h0_mem) begin
      w_s0 = '{pc: w_h1.pc, instr: w_h1.instr, rs: w_h1.rs, rt: w_h1.rt,
               dst: w_h1.dst, reg_write: w_h1.reg_write};
    end else begin
      w_s0 = '{pc: w_h0.pc, instr: w_h0.instr, rs: w_h0.rs, rt: w_h0.rt,
               dst: w_h0.dst, reg_write: w_h0.reg_write};
    end
  end

  // Issue registers and load-use tracker; stall freezes both, flush empties the slots.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_s0       <= '0;
      r_s1       <= '0;
      r_s0_valid <= 1'b0;
      r_s1_valid <= 1'b0;
      r_first    <= 1'b1;
      r_ld_valid <= 1'b0;
      r_ld_dst   <= '0;
    end else if (flush) begin
      r_s0_valid <= 1'b0;
      r_s1_valid <= 1'b0;
      r_first    <= 1'b1;
      r_ld_valid <= 1'b0;
    end else if (!stall) begin
      r_s0       <= w_s0;
      r_s1       <= w_s1;
      r_s0_valid <= w_s0_valid;
      r_s1_valid <= w_s1_valid;
      r_first    <= w_first;
      r_ld_valid <= w_s1_valid && w_s1.mem_read && w_s1.reg_write && (w_s1.dst != '0);
      r_ld_dst   <= w_s1.dst;
    end
  end

  assign slot0_valid     = r_s0_valid;
  assign slot0_pc        = r_s0.pc;
  assign slot0_instr     = r_s0.instr;
  assign slot0_rs        = r_s0.rs;
  assign slot0_rt        = r_s0.rt;
  assign slot0_dst       = r_s0.dst;
  assign slot0_reg_write = r_s0.reg_write;
  assign slot1_valid     = r_s1_valid;
  assign slot1_pc        = r_s1.pc;
  assign slot1_instr     = r_s1.instr;
  assign slot1_rs        = r_s1.rs;
  assign slot1_rt        = r_s1.rt;
  assign slot1_dst       = r_s1.dst;
  assign slot1_reg_write = r_s1.reg_write;
  assign slot1_mem_read  = r_s1.mem_read;
  assign slot1_mem_write = r_s1.mem_write;
  assign first           = r_first;

endmodule

// File: tb/tb_issue_unit.sv
// Bench for issue_unit: directed scenarios plus randomized traffic against a queue model.
module tb_issue_unit;
  import issue_unit_pkg::*;

  localparam int DEPTH = 4;
  localparam int RW    = NUM_REGISTERS_LOG2;

  logic          clk = 1'b0;
  logic          reset, flush, stall;
  logic [1:0]    in_valid;
  logic          in_ready;
  logic [31:0]   in0_pc, in1_pc, in0_instr, in1_instr;
  logic [RW-1:0] in0_rs, in0_rt, in0_dst, in1_rs, in1_rt, in1_dst;
  logic          in0_reg_write, in0_mem_read, in0_mem_write;
  logic          in1_reg_write, in1_mem_read, in1_mem_write;
  logic          slot0_valid, slot0_reg_write;
  logic [31:0]   slot0_pc, slot0_instr;
  logic [RW-1:0] slot0_rs, slot0_rt, slot0_dst;
  logic          slot1_valid, slot1_reg_write, slot1_mem_read, slot1_mem_write;
  logic [31:0]   slot1_pc, slot1_instr;
  logic [RW-1:0] slot1_rs, slot1_rt, slot1_dst;
  logic          first;

  int checks = 0;
  int errors = 0;

  // Reference model state
  entry_t  mq[$];
  entry_t  m_s0, m_s1;
  bit      m_s0v, m_s1v, m_first, m_ldv;
  reg_idx_t m_ldd;

  always #5 clk = ~clk;

  issue_unit #(.DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .flush(flush), .stall(stall),
    .in_valid(in_valid), .in_ready(in_ready),
    .in0_pc(in0_pc), .in1_pc(in1_pc), .in0_instr(in0_instr), .in1_instr(in1_instr),
    .in0_rs(in0_rs), .in0_rt(in0_rt), .in0_dst(in0_dst),
    .in1_rs(in1_rs), .in1_rt(in1_rt), .in1_dst(in1_dst),
    .in0_reg_write(in0_reg_write), .in0_mem_read(in0_mem_read), .in0_mem_write(in0_mem_write),
    .in1_reg_write(in1_reg_write), .in1_mem_read(in1_mem_read), .in1_mem_write(in1_mem_write),
    .slot0_valid(slot0_valid), .slot0_pc(slot0_pc), .slot0_instr(slot0_instr),
    .slot0_rs(slot0_rs), .slot0_rt(slot0_rt), .slot0_dst(slot0_dst),
    .slot0_reg_write(slot0_reg_write),
    .slot1_valid(slot1_valid), .slot1_pc(slot1_pc), .slot1_instr(slot1_instr),
    .slot1_rs(slot1_rs), .slot1_rt(slot1_rt), .slot1_dst(slot1_dst),
    .slot1_reg_write(slot1_reg_write), .slot1_mem_read(slot1_mem_read),
    .slot1_mem_write(slot1_mem_write),
    .first(first)
  );

  function automatic entry_t mk(input logic [31:0] pc, input int rs, input int rt, input int dst,
                                input logic rw, input logic mr, input logic mw);
    entry_t e;
    e.pc = pc; e.instr = {pc[15:0], 16'hC0DE};
    e.rs = RW'(rs); e.rt = RW'(rt); e.dst = RW'(dst);
    e.reg_write = rw; e.mem_read = mr; e.mem_write = mw;
    return e;
  endfunction

  task automatic drive(input entry_t a, input entry_t b, input logic [1:0] v);
    in0_pc = a.pc; in0_instr = a.instr; in0_rs = a.rs; in0_rt = a.rt; in0_dst = a.dst;
    in0_reg_write = a.reg_write; in0_mem_read = a.mem_read; in0_mem_write = a.mem_write;
    in1_pc = b.pc; in1_instr = b.instr; in1_rs = b.rs; in1_rt = b.rt; in1_dst = b.dst;
    in1_reg_write = b.reg_write; in1_mem_read = b.mem_read; in1_mem_write = b.mem_write;
    in_valid = v;
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    in_valid = 2'b00;
    repeat (n) tick();
  endtask

  task automatic test_reset;
    reset = 1'b1; flush = 1'b0; stall = 1'b0;
    drive('0, '0, 2'b00);
    tick(); tick();
    reset = 1'b0;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
    checks++; if ({slot0_valid, slot1_valid} !== 2'b00) begin errors++; $display("FAIL reset_valids: got %b want 00", {slot0_valid, slot1_valid}); end
    checks++; if (first !== 1'b1) begin errors++; $display("FAIL reset_first: got %b want 1", first); end
    checks++; if ({slot0_pc, slot1_pc, slot1_dst} !== '0) begin errors++; $display("FAIL reset_payload: got %h/%h/%h want 0", slot0_pc, slot1_pc, slot1_dst); end
  endtask

  task automatic test_pair_alu_mem;
    entry_t add_i, lw_i;
    add_i = mk(32'h100, 2, 3, 1, 1'b1, 1'b0, 1'b0);
    lw_i  = mk(32'h104, 5, 4, 4, 1'b1, 1'b1, 1'b0);
    drive(add_i, lw_i, 2'b11); tick();
    in_valid = 2'b00; tick();
    checks++; if ({slot0_valid, slot0_pc} !== {1'b1, 32'h100}) begin errors++; $display("FAIL alu_mem_slot0: got v=%b pc=%h want v=1 pc=100", slot0_valid, slot0_pc); end
    checks++; if ({slot1_valid, slot1_pc, slot1_mem_read} !== {1'b1, 32'h104, 1'b1}) begin errors++; $display("FAIL alu_mem_slot1: got v=%b pc=%h mr=%b want v=1 pc=104 mr=1", slot1_valid, slot1_pc, slot1_mem_read); end
    checks++; if (first !== 1'b1) begin errors++; $display("FAIL alu_mem_first: got %b want 1", first); end
    idle(2);
  endtask

  task automatic test_pair_mem_first;
    entry_t lw_i, add_i;
    lw_i  = mk(32'h200, 5, 4, 4, 1'b1, 1'b1, 1'b0);
    add_i = mk(32'h204, 7, 8, 6, 1'b1, 1'b0, 1'b0);
    drive(lw_i, add_i, 2'b11); tick();
    in_valid = 2'b00; tick();
    checks++; if ({slot1_valid, slot1_pc} !== {1'b1, 32'h200}) begin errors++; $display("FAIL mem_first_slot1: got v=%b pc=%h want v=1 pc=200", slot1_valid, slot1_pc); end
    checks++; if ({slot0_valid, slot0_pc, slot0_dst} !== {1'b1, 32'h204, RW'(6)}) begin errors++; $display("FAIL mem_first_slot0: got v=%b pc=%h dst=%0d want v=1 pc=204 dst=6", slot0_valid, slot0_pc, slot0_dst); end
    checks++; if (first !== 1'b0) begin errors++; $display("FAIL mem_first_first: got %b want 0", first); end
    idle(2);
  endtask

  task automatic test_dependence;
    entry_t add_i, sub_i;
    add_i = mk(32'h300, 1, 2, 5, 1'b1, 1'b0, 1'b0);
    sub_i = mk(32'h304, 5, 3, 6, 1'b1, 1'b0, 1'b0);
    drive(add_i, sub_i, 2'b11); tick();
    in_valid = 2'b00; tick();
    checks++; if ({slot0_valid, slot0_pc, slot1_valid, first} !== {1'b1, 32'h300, 1'b0, 1'b1}) begin errors++; $display("FAIL dep_cycle1: got s0=%b pc=%h s1=%b first=%b want 1 300 0 1", slot0_valid, slot0_pc, slot1_valid, first); end
    tick();
    checks++; if ({slot0_valid, slot0_pc, slot1_valid, first} !== {1'b1, 32'h304, 1'b0, 1'b1}) begin errors++; $display("FAIL dep_cycle2: got s0=%b pc=%h s1=%b first=%b want 1 304 0 1", slot0_valid, slot0_pc, slot1_valid, first); end
    idle(2);
  endtask

  task automatic test_load_use;
    entry_t lw_i, add_i;
    lw_i  = mk(32'h400, 2, 7, 7, 1'b1, 1'b1, 1'b0);
    add_i = mk(32'h404, 7, 1, 8, 1'b1, 1'b0, 1'b0);
    drive(lw_i, add_i, 2'b11); tick();
    in_valid = 2'b00; tick();
    checks++; if ({slot1_valid, slot1_pc, slot0_valid} !== {1'b1, 32'h400, 1'b0}) begin errors++; $display("FAIL load_use_lw: got s1=%b pc=%h s0=%b want 1 400 0", slot1_valid, slot1_pc, slot0_valid); end
    tick();
    checks++; if ({slot0_valid, slot1_valid, first} !== 3'b001) begin errors++; $display("FAIL load_use_bubble: got s0=%b s1=%b first=%b want 0 0 1", slot0_valid, slot1_valid, first); end
    tick();
    checks++; if ({slot0_valid, slot0_pc, slot1_valid} !== {1'b1, 32'h404, 1'b0}) begin errors++; $display("FAIL load_use_add: got s0=%b pc=%h s1=%b want 1 404 0", slot0_valid, slot0_pc, slot1_valid); end
    idle(2);
  endtask

  task automatic test_stall_flush;
    drive(mk(32'h500, 2, 3, 1, 1'b1, 1'b0, 1'b0), mk(32'h504, 10, 11, 9, 1'b1, 1'b0, 1'b0), 2'b11);
    tick();
    in_valid = 2'b00; tick();
    stall = 1'b1;
    drive(mk(32'h600, 1, 1, 2, 1'b1, 1'b0, 1'b0), mk(32'h604, 1, 1, 3, 1'b1, 1'b0, 1'b0), 2'b11);
    tick();
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL stall_half_ready: got %b want 1", in_ready); end
    drive(mk(32'h608, 1, 1, 2, 1'b1, 1'b0, 1'b0), mk(32'h60C, 1, 1, 3, 1'b1, 1'b0, 1'b0), 2'b11);
    tick();
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL stall_full_ready: got %b want 0", in_ready); end
    tick();
    checks++; if ({slot0_valid, slot0_pc, slot1_valid, slot1_pc, first} !== {1'b1, 32'h500, 1'b1, 32'h504, 1'b1}) begin errors++; $display("FAIL stall_frozen: got s0=%b %h s1=%b %h first=%b want 1 500 1 504 1", slot0_valid, slot0_pc, slot1_valid, slot1_pc, first); end
    flush = 1'b1;
    tick();
    checks++; if ({slot0_valid, slot1_valid, first, in_ready} !== 4'b0011) begin errors++; $display("FAIL flush_state: got s0=%b s1=%b first=%b rdy=%b want 0 0 1 1", slot0_valid, slot1_valid, first, in_ready); end
    flush = 1'b0; stall = 1'b0; in_valid = 2'b00;
    tick();
    checks++; if ({slot0_valid, slot1_valid} !== 2'b00) begin errors++; $display("FAIL flush_empty: got s0=%b s1=%b want 0 0", slot0_valid, slot1_valid); end
  endtask

  function automatic bit m_blocked(input entry_t e);
    return m_ldv && ((e.rs == m_ldd) || (e.rt == m_ldd));
  endfunction

  function automatic bit m_mem(input entry_t e);
    return e.mem_read || e.mem_write;
  endfunction

  function automatic entry_t rand_entry(input logic [31:0] pc);
    int kind;
    kind = int'($urandom_range(0, 3));
    case (kind)
      0:       return mk(pc, int'($urandom_range(0, 7)), int'($urandom_range(0, 7)), int'($urandom_range(0, 7)), 1'b1, 1'b0, 1'b0);
      1:       return mk(pc, int'($urandom_range(0, 7)), int'($urandom_range(0, 7)), int'($urandom_range(0, 7)), 1'b1, 1'b1, 1'b0);
      2:       return mk(pc, int'($urandom_range(0, 7)), int'($urandom_range(0, 7)), int'($urandom_range(0, 7)), 1'b0, 1'b0, 1'b1);
      default: return mk(pc, int'($urandom_range(0, 7)), int'($urandom_range(0, 7)), int'($urandom_range(0, 7)), 1'b0, 1'b0, 1'b0);
    endcase
  endfunction

  task automatic test_random;
    logic [31:0] pc_ctr;
    logic [1:0]  v;
    entry_t      a, b;
    bit          rdy;
    int          n;
    pc_ctr = 32'h1000;
    reset = 1'b1; flush = 1'b0; stall = 1'b0; in_valid = 2'b00;
    tick();
    reset = 1'b0;
    mq.delete(); m_s0 = '0; m_s1 = '0; m_s0v = 0; m_s1v = 0; m_first = 1; m_ldv = 0; m_ldd = '0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      stall = ($urandom_range(0, 99) < 20);
      flush = ($urandom_range(0, 99) < 3);
      reset = ($urandom_range(0, 999) < 3);
      v = 2'($urandom_range(0, 3));
      if (v == 2'b10) v = 2'b00;
      a = rand_entry(pc_ctr);
      b = rand_entry(pc_ctr + 32'd4);
      pc_ctr += 32'd8;
      drive(a, b, v);
      rdy = (mq.size() <= DEPTH - 2);
      if (reset) begin
        mq.delete(); m_s0 = '0; m_s1 = '0; m_s0v = 0; m_s1v = 0; m_first = 1; m_ldv = 0;
      end else if (flush) begin
        mq.delete(); m_s0v = 0; m_s1v = 0; m_first = 1; m_ldv = 0;
      end else begin
        if (!stall) begin
          n = 0; m_s0v = 0; m_s1v = 0; m_first = 1;
          if (mq.size() > 0 && !m_blocked(mq[0])) begin
            n = 1;
            if (mq.size() > 1 && !m_blocked(mq[1]) && !(m_mem(mq[0]) && m_mem(mq[1])) &&
                !(mq[0].reg_write && mq[0].dst != 0 && (mq[1].rs == mq[0].dst || mq[1].rt == mq[0].dst)))
              n = 2;
          end
          if (n == 1) begin
            if (m_mem(mq[0])) begin m_s1 = mq[0]; m_s1v = 1; end
            else begin m_s0 = mq[0]; m_s0v = 1; end
          end else if (n == 2) begin
            if (m_mem(mq[0])) begin m_s1 = mq[0]; m_s0 = mq[1]; m_first = 0; end
            else begin m_s0 = mq[0]; m_s1 = mq[1]; end
            m_s0v = 1; m_s1v = 1;
          end
          m_ldv = m_s1v && m_s1.mem_read && m_s1.reg_write && (m_s1.dst != 0);
          m_ldd = m_s1.dst;
          repeat (n) void'(mq.pop_front());
        end
        if (v[0] && rdy) begin
          mq.push_back(a);
          if (v[1]) mq.push_back(b);
        end
      end
      tick();
      checks++; if (in_ready !== (mq.size() <= DEPTH - 2)) begin errors++; $display("FAIL rand_in_ready cyc=%0d: got %b want %b", cyc, in_ready, (mq.size() <= DEPTH - 2)); end
      checks++; if ({slot0_valid, slot1_valid, first} !== {m_s0v, m_s1v, m_first}) begin errors++; $display("FAIL rand_ctrl cyc=%0d: got s0=%b s1=%b first=%b want %b %b %b", cyc, slot0_valid, slot1_valid, first, m_s0v, m_s1v, m_first); end
      if (m_s0v) begin
        checks++; if ({slot0_pc, slot0_instr, slot0_rs, slot0_rt, slot0_dst, slot0_reg_write} !== {m_s0.pc, m_s0.instr, m_s0.rs, m_s0.rt, m_s0.dst, m_s0.reg_write}) begin errors++; $display("FAIL rand_slot0 cyc=%0d: got pc=%h dst=%0d want pc=%h dst=%0d", cyc, slot0_pc, slot0_dst, m_s0.pc, m_s0.dst); end
      end
      if (m_s1v) begin
        checks++; if ({slot1_pc, slot1_instr, slot1_rs, slot1_rt, slot1_dst, slot1_reg_write, slot1_mem_read, slot1_mem_write} !== m_s1) begin errors++; $display("FAIL rand_slot1 cyc=%0d: got pc=%h dst=%0d want pc=%h dst=%0d", cyc, slot1_pc, slot1_dst, m_s1.pc, m_s1.dst); end
      end
    end
    reset = 1'b0; flush = 1'b0; stall = 1'b0; in_valid = 2'b00;
  endtask

  initial begin
    test_reset();
    test_pair_alu_mem();
    test_pair_mem_first();
    test_dependence();
    test_load_use();
    test_stall_flush();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
